// File: rtl/pipeline_pkg.sv
// Shared definitions for the in-order pipeline: sequencer states and
// control-word geometry used by the stage registers.
package pipeline_pkg;

  localparam int LOADS_BIT = 8;
  localparam int CONTROL_W = 22;
  localparam int REGNUM_W  = 3;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    LD_STALL = 3'd1,
    MEM_WAIT = 3'd2,
    HALTED   = 3'd3
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (i_en && (r_count != {W{1'b1}}))
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: per-stage update enables and NOP-inject strobes for
// load-use stalls, memory waits, taken-branch squashes and halt.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_valid,
  input  logic [REGNUM_W-1:0] dec_num_Rm,
  input  logic [REGNUM_W-1:0] dec_num_Rn,
  input  logic                dec_uses_Rm,
  input  logic                dec_uses_Rn,
  input  logic                s1_loads,
  input  logic [REGNUM_W-1:0] s1_num_Rd,
  input  logic                mem_req,
  input  logic                mem_ready,
  input  logic                branch_taken,
  input  logic                halt_in,
  output logic                update_f,
  output logic                update_1,
  output logic                update_2,
  output logic                update_3,
  output logic                bubble_1,
  output logic                bubble_2,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    stall_count
);

  state_t     r_state, w_next, w_eff;
  logic       r_retLd, w_retLdNext;
  logic [1:0] r_cnt, w_cntNext;
  logic       w_hazard, w_memwait;
  logic       w_updF, w_upd1, w_upd2, w_upd3, w_bub1, w_bub2;
  logic       w_stallEn;

  assign w_hazard = dec_valid & s1_loads &
                    ((dec_uses_Rm & (dec_num_Rm == s1_num_Rd)) |
                     (dec_uses_Rn & (dec_num_Rn == s1_num_Rd)));
  assign w_memwait = mem_req & ~mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_retLd <= 1'b0;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_next;
      r_retLd <= w_retLdNext;
      r_cnt   <= w_cntNext;
    end
  end

  // A finished memory wait behaves as whichever state it interrupted.
  always_comb begin
    w_next      = r_state;
    w_retLdNext = r_retLd;
    w_cntNext   = r_cnt;
    w_updF      = 1'b0;
    w_upd1      = 1'b0;
    w_upd2      = 1'b0;
    w_upd3      = 1'b0;
    w_bub1      = 1'b0;
    w_bub2      = 1'b0;
    w_eff       = (r_state == MEM_WAIT) ? (r_retLd ? LD_STALL : RUN) : r_state;

    if (r_state == HALTED) begin
      w_next = HALTED;
    end else if (w_memwait) begin
      if (r_state != MEM_WAIT) begin
        w_retLdNext = (r_state == LD_STALL);
        w_next      = MEM_WAIT;
      end
    end else if (halt_in) begin
      w_next = HALTED;
    end else if (branch_taken) begin
      {w_updF, w_upd1, w_upd2, w_upd3} = 4'b1111;
      w_bub1    = 1'b1;
      w_bub2    = 1'b1;
      w_cntNext = 2'd0;
      w_next    = RUN;
    end else if (w_eff == LD_STALL) begin
      {w_updF, w_upd1, w_upd2, w_upd3} = 4'b0111;
      w_bub1    = 1'b1;
      w_cntNext = r_cnt - 2'd1;
      w_next    = (r_cnt == 2'd1) ? RUN : LD_STALL;
    end else if (w_hazard) begin
      {w_updF, w_upd1, w_upd2, w_upd3} = 4'b0111;
      w_bub1 = 1'b1;
      if (LOAD_BUBBLES == 1) begin
        w_next = RUN;
      end else begin
        w_cntNext = 2'(LOAD_BUBBLES - 1);
        w_next    = LD_STALL;
      end
    end else begin
      {w_updF, w_upd1, w_upd2, w_upd3} = 4'b1111;
      w_next = RUN;
    end
  end

  assign update_f = rst & w_updF;
  assign update_1 = rst & w_upd1;
  assign update_2 = rst & w_upd2;
  assign update_3 = rst & w_upd3;
  assign bubble_1 = rst & w_bub1;
  assign bubble_2 = rst & w_bub2;
  assign state    = r_state;

  assign w_stallEn = rst & ~update_f;

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk     (clk),
    .rst_n   (rst),
    .i_en    (w_stallEn),
    .o_count (stall_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a two-bubble/4-bit-counter main
// instance plus a single-bubble instance sharing the same stimulus.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       dec_valid, dec_uses_Rm, dec_uses_Rn, s1_loads;
  logic [2:0] dec_num_Rm, dec_num_Rn, s1_num_Rd;
  logic       mem_req, mem_ready, branch_taken, halt_in;

  logic       update_f, update_1, update_2, update_3, bubble_1, bubble_2;
  logic [2:0] state;
  logic [3:0] stall_count;
  logic       b_update_f, b_update_1, b_update_2, b_update_3, b_bubble_1, b_bubble_2;
  logic [2:0] b_state;
  logic [15:0] b_stall_count;

  logic [5:0] ctl;
  int vectors = 0;
  int miscompares = 0;

  localparam logic [5:0] CTL_RUN    = 6'b111100;
  localparam logic [5:0] CTL_STALL  = 6'b011110;
  localparam logic [5:0] CTL_FREEZE = 6'b000000;
  localparam logic [5:0] CTL_BRANCH = 6'b111111;

  assign ctl = {update_f, update_1, update_2, update_3, bubble_1, bubble_2};

  pipeline_hazard_ctrl #(.LOAD_BUBBLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_num_Rm(dec_num_Rm),
    .dec_num_Rn(dec_num_Rn), .dec_uses_Rm(dec_uses_Rm), .dec_uses_Rn(dec_uses_Rn),
    .s1_loads(s1_loads), .s1_num_Rd(s1_num_Rd), .mem_req(mem_req),
    .mem_ready(mem_ready), .branch_taken(branch_taken), .halt_in(halt_in),
    .update_f(update_f), .update_1(update_1), .update_2(update_2),
    .update_3(update_3), .bubble_1(bubble_1), .bubble_2(bubble_2),
    .state(state), .stall_count(stall_count)
  );

  pipeline_hazard_ctrl #(.LOAD_BUBBLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_num_Rm(dec_num_Rm),
    .dec_num_Rn(dec_num_Rn), .dec_uses_Rm(dec_uses_Rm), .dec_uses_Rn(dec_uses_Rn),
    .s1_loads(s1_loads), .s1_num_Rd(s1_num_Rd), .mem_req(mem_req),
    .mem_ready(mem_ready), .branch_taken(branch_taken), .halt_in(halt_in),
    .update_f(b_update_f), .update_1(b_update_1), .update_2(b_update_2),
    .update_3(b_update_3), .bubble_1(b_bubble_1), .bubble_2(b_bubble_2),
    .state(b_state), .stall_count(b_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [2:0] rm, input logic [2:0] rn,
                               input logic urm, input logic urn, input logic ld,
                               input logic [2:0] rd, input logic mreq, input logic mrdy,
                               input logic br, input logic halt);
    dec_valid = v;  dec_num_Rm = rm;  dec_num_Rn = rn;
    dec_uses_Rm = urm;  dec_uses_Rn = urn;  s1_loads = ld;  s1_num_Rd = rd;
    mem_req = mreq;  mem_ready = mrdy;  branch_taken = br;  halt_in = halt;
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] expCtl,
                             input logic [2:0] expState, input logic [3:0] expStall);
    vectors++;
    assert (ctl === expCtl) else begin
      miscompares++;
      $error("[TB] FAIL %s ctl: observed %b expected %b", tag, ctl, expCtl);
    end
    vectors++;
    assert (state === expState) else begin
      miscompares++;
      $error("[TB] FAIL %s state: observed %0d expected %0d", tag, state, expState);
    end
    vectors++;
    assert (stall_count === expStall) else begin
      miscompares++;
      $error("[TB] FAIL %s stall_count: observed %0d expected %0d", tag, stall_count, expStall);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("reset", CTL_FREEZE, 3'd0, 4'd0);
    nextCycle();
    rst = 1'b1;

    applyStimulus(1, 3'd1, 3'd2, 1, 1, 0, 3'd3, 0, 0, 0, 0);
    @(negedge clk); checkOutput("normal", CTL_RUN, 3'd0, 4'd0);
    nextCycle();

    applyStimulus(1, 3'd3, 3'd3, 0, 0, 1, 3'd3, 0, 0, 0, 0);
    @(negedge clk); checkOutput("no_hazard_unused", CTL_RUN, 3'd0, 4'd0);
    nextCycle();

    applyStimulus(1, 3'd4, 3'd3, 1, 0, 1, 3'd3, 0, 0, 0, 0);
    @(negedge clk); checkOutput("no_hazard_diff_reg", CTL_RUN, 3'd0, 4'd0);
    nextCycle();

    applyStimulus(1, 3'd3, 3'd0, 1, 0, 1, 3'd3, 0, 0, 0, 0);
    @(negedge clk); checkOutput("hazard_rm", CTL_STALL, 3'd0, 4'd0);
    checkBit("lb1_hazard_updf", b_update_f, 1'b0);
    nextCycle();

    applyStimulus(1, 3'd3, 3'd0, 1, 0, 0, 3'd3, 0, 0, 0, 0);
    @(negedge clk); checkOutput("ld_stall_2nd", CTL_STALL, 3'd1, 4'd1);
    checkBit("lb1_after_hazard_updf", b_update_f, 1'b1);
    checkBit("lb1_stays_run", (b_state === 3'd0), 1'b1);
    nextCycle();

    @(negedge clk); checkOutput("resume_after_load", CTL_RUN, 3'd0, 4'd2);
    nextCycle();

    applyStimulus(1, 3'd0, 3'd5, 0, 1, 1, 3'd5, 0, 0, 0, 0);
    @(negedge clk); checkOutput("hazard_rn", CTL_STALL, 3'd0, 4'd2);
    nextCycle();

    applyStimulus(1, 3'd0, 3'd5, 0, 1, 0, 3'd5, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("memwait_%0d", i), CTL_FREEZE,
                  (i == 0) ? 3'd1 : 3'd2, 4'(3 + i));
      nextCycle();
    end

    applyStimulus(1, 3'd0, 3'd5, 0, 1, 0, 3'd5, 1, 1, 0, 0);
    @(negedge clk); checkOutput("memdone_bubble", CTL_STALL, 3'd2, 4'd7);
    nextCycle();

    // mem_ready with no request must not disturb normal flow
    applyStimulus(1, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1, 0, 0);
    @(negedge clk); checkOutput("ready_no_req", CTL_RUN, 3'd0, 4'd8);
    nextCycle();

    applyStimulus(1, 3'd0, 3'd0, 0, 0, 0, 3'd0, 1, 0, 0, 0);
    @(negedge clk); checkOutput("memwait_run", CTL_FREEZE, 3'd0, 4'd8);
    nextCycle();
    applyStimulus(1, 3'd0, 3'd0, 0, 0, 0, 3'd0, 1, 1, 0, 0);
    @(negedge clk); checkOutput("memdone_run", CTL_RUN, 3'd2, 4'd9);
    nextCycle();

    applyStimulus(1, 3'd3, 3'd0, 1, 0, 1, 3'd3, 0, 0, 1, 0);
    @(negedge clk); checkOutput("branch_vs_hazard", CTL_BRANCH, 3'd0, 4'd9);
    nextCycle();
    applyStimulus(1, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    @(negedge clk); checkOutput("after_branch", CTL_RUN, 3'd0, 4'd9);
    nextCycle();

    applyStimulus(1, 3'd3, 3'd0, 1, 0, 1, 3'd3, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 1, 0);
    @(negedge clk); checkOutput("branch_cancels_ld", CTL_BRANCH, 3'd1, 4'd10);
    nextCycle();
    applyStimulus(1, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    @(negedge clk); checkOutput("after_cancel", CTL_RUN, 3'd0, 4'd10);
    nextCycle();

    applyStimulus(1, 3'd0, 3'd0, 0, 0, 0, 3'd0, 1, 0, 0, 1);
    @(negedge clk); checkOutput("memwait_over_halt", CTL_FREEZE, 3'd0, 4'd10);
    nextCycle();
    applyStimulus(1, 3'd0, 3'd0, 0, 0, 0, 3'd0, 1, 1, 0, 1);
    @(negedge clk); checkOutput("halt_take", CTL_FREEZE, 3'd2, 4'd11);
    nextCycle();
    applyStimulus(1, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 1, 0);
    @(negedge clk); checkOutput("halted", CTL_FREEZE, 3'd3, 4'd12);
    repeat (20) nextCycle();
    @(negedge clk); checkOutput("halted_saturated", CTL_FREEZE, 3'd3, 4'd15);

    // Reset out of HALTED, then build a memory wait and reset mid-wait
    rst = 1'b0;
    #1;
    checkOutput("reset_from_halt", CTL_FREEZE, 3'd0, 4'd0);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1, 3'd0, 3'd0, 0, 0, 0, 3'd0, 1, 0, 0, 0);
    repeat (5) nextCycle();
    @(negedge clk); checkOutput("memwait_pre_reset", CTL_FREEZE, 3'd2, 4'd5);
    rst = 1'b0;
    #1;
    checkOutput("reset_mid_memwait", CTL_FREEZE, 3'd0, 4'd0);
    applyStimulus(1, 3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    nextCycle();
    @(negedge clk); checkOutput("reset_held", CTL_FREEZE, 3'd0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the in-order pipeline: generates the per-stage `update` enables and bubble (NOP-inject) strobes for fetch, stage 1 (readreg), stage 2 (execute) and stage 3 (memory/writeback).
- Resolves load-use hazards, multi-cycle memory waits, taken-branch squashes and halt.
- Sits beside the pipeline registers. It consumes the stage-1 `loads` flag and register numbers, and drives the `update` inputs of every stage register.

Parameters:
- LOAD_BUBBLES, 1, number of bubble cycles inserted per load-use hazard (1..3).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- dec_valid  input  1  decode stage holds a real instruction.
- dec_num_Rm  input  3  decode-stage Rm number.
- dec_num_Rn  input  3  decode-stage Rn number.
- dec_uses_Rm  input  1  decode instruction reads Rm.
- dec_uses_Rn  input  1  decode instruction reads Rn.
- s1_loads  input  1  stage-1 instruction is a load (control bit 8 of stage-1 control).
- s1_num_Rd  input  3  stage-1 destination register.
- mem_req  input  1  stage-3 memory access in progress.
- mem_ready  input  1  memory completes access this cycle.
- branch_taken  input  1  stage-2 branch resolved taken.
- halt_in  input  1  HALT instruction reached stage 3.
- update_f  output  1  enable for the PC/fetch register.
- update_1  output  1  enable for the stage-1 register.
- update_2  output  1  enable for the stage-2 register.
- update_3  output  1  enable for the stage-3 register.
- bubble_1  output  1  force stage-1 control input to all-zero (NOP).
- bubble_2  output  1  force stage-2 control input to all-zero.
- state  output  3  current FSM state encoding.
- stall_count  output  CNT_W  saturating count of cycles with update_f=0.

Behaviour:
- FSM states: RUN=0, LD_STALL=1, MEM_WAIT=2, HALTED=3. Registered state, async reset to RUN.
- While rst=0: all update_* and bubble_* are 0, state=RUN, bubble counter=0, stall_count=0.
- Outputs are combinational from state and inputs. No added latency; the stage registers act on the same clock edge.
- hazard = dec_valid & s1_loads & ((dec_uses_Rm & dec_num_Rm==s1_num_Rd) | (dec_uses_Rn & dec_num_Rn==s1_num_Rd)).
- memwait = mem_req & ~mem_ready.
- Priority each cycle: HALTED > memwait > branch_taken > hazard/LD_STALL > normal.
- HALTED: all update_*=0 and bubble_*=0. No exit except reset.
- halt_in=1 (not memwait): updates all 0, next state HALTED.
- memwait (RUN or LD_STALL): all update_*=0, no bubbles.
  - Next state is MEM_WAIT.
  - The bubble counter is preserved, and LD_STALL resumes after the wait.
  - A return state bit is kept.
- MEM_WAIT: the same freeze while memwait holds.
  - On mem_ready=1, updates resume that same cycle under the normal rules.
  - Next state is the saved return state.
- branch_taken (not memwait):
  - update_f=update_1=update_2=update_3=1, bubble_1=1, bubble_2=1.
  - Bubble counter cleared, next state RUN.
  - A pending load stall is cancelled.
- hazard in RUN:
  - update_f=0, update_1=1 with bubble_1=1, update_2=update_3=1.
  - If LOAD_BUBBLES=1, stay in RUN.
  - Otherwise load counter=LOAD_BUBBLES-1 and go to LD_STALL.
- LD_STALL: same outputs as hazard. Decrement the counter; at 1, next state RUN.
- Normal: all update_*=1, bubbles 0.
- stall_count increments each cycle update_f=0 and rst=1. It saturates at all-ones and never wraps.
- mem_ready without mem_req is ignored.
- branch_taken and hazard in the same cycle: branch wins, no stall.

Decomposition:
- Shared package pipeline_pkg holds:
  - state enum (RUN/LD_STALL/MEM_WAIT/HALTED);
  - LOADS_BIT=8;
  - CONTROL_W=22;
  - REGNUM_W=3.
- One sub-module, sat_counter (CNT_W, enable, saturating), used for stall_count.

Test Plan:
- Reset mid-operation: assert rst=0 while state=MEM_WAIT with stall_count=5 -> immediately state=0, stall_count=0, all update_*=0.
- Load-use: s1_loads=1, s1_num_Rd=3, dec_num_Rm=3, dec_uses_Rm=1, LOAD_BUBBLES=2 -> two cycles of update_f=0 and bubble_1=1, then all updates 1; stall_count=2.
- No false hazard: same setup with dec_uses_Rm=0, or Rd=3 vs Rm=4 -> update_f=1, bubble_1=0.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles during LD_STALL -> all updates 0 for 4 cycles. On mem_ready=1, updates resume and the remaining bubble still issues; stall_count=+5.
- Branch vs hazard: branch_taken=1 and hazard together -> bubble_1=bubble_2=1, update_f=1, next state RUN.
- Halt and saturation: halt_in=1 -> state=3 with updates 0 forever. With CNT_W=4, after 20 halted cycles stall_count=15.
